// File: rtl/lc_bank_ctrl_if.sv
// CPU-side bus and status bundle for the language-card bank controller.
interface lc_bank_ctrl_if #(
    parameter int BW = 1
);
    logic          busValid;
    logic [15:0]   address;
    logic          rw;
    logic          lcRead;
    logic          lcWrite;
    logic [BW+13:0] lcAddr;
    logic          statusHit;
    logic          statusBit;
    logic [BW-1:0] bankSel;
    logic          readRam;
    logic          writeEn;
    logic          bank2;

    modport master (
        output busValid, address, rw,
        input  lcRead, lcWrite, lcAddr, statusHit, statusBit,
        input  bankSel, readRam, writeEn, bank2
    );

    modport slave (
        input  busValid, address, rw,
        output lcRead, lcWrite, lcAddr, statusHit, statusBit,
        output bankSel, readRam, writeEn, bank2
    );
endinterface

// File: rtl/lc_bank_ctrl.sv
// Language-card / Saturn bank controller for $D000-$FFFF with $C011/$C012 status.
// Decode is 0-cycle from pre-update state; soft-switch state lands 1 cycle later; no backpressure.
module lc_bank_ctrl #(
    parameter int NUM_BANKS   = 1,
    parameter int SLOT        = 0,
    parameter int SATURN_MODE = 0
) (
    input  logic          clk6502,
    input  logic          cpuRst,
    lc_bank_ctrl_if.slave bus
);
    localparam int          BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [11:0] SW_PAGE   = 12'hC08 + 12'(SLOT);
    localparam logic [2:0]  BANK_MASK = 3'(NUM_BANKS - 1);

    logic          read_ram;
    logic          write_en;
    logic          pre_write;
    logic          bank2_q;
    logic [BW-1:0] bank_sel;
    logic [BW-1:0] bank_nxt;
    logic [3:0]    n;
    logic          sw_hit;
    logic          saturn_sw;
    logic          hi_hit;
    logic          stat_rd;
    logic [13:0]   off14;

    assign n         = bus.address[3:0];
    assign sw_hit    = bus.busValid && (bus.address[15:4] == SW_PAGE);
    assign saturn_sw = (SATURN_MODE != 0) && n[2];
    // Bank number wraps modulo NUM_BANKS so a 1-bank card ignores bank switches.
    assign bank_nxt  = BW'({n[3], n[1:0]} & BANK_MASK);
    assign hi_hit    = bus.address[15:12] >= 4'hD;
    assign stat_rd   = bus.busValid && bus.rw &&
                       ((bus.address == 16'hC011) || (bus.address == 16'hC012));

    always_ff @(posedge clk6502) begin
        if (cpuRst) begin
            read_ram  <= 1'b0;
            write_en  <= 1'b0;
            pre_write <= 1'b0;
            bank2_q   <= 1'b1;
            bank_sel  <= '0;
        end else if (sw_hit) begin
            if (saturn_sw) begin
                bank_sel <= bank_nxt;
            end else begin
                bank2_q  <= !n[3];
                read_ram <= (n[1:0] == 2'b00) || (n[1:0] == 2'b11);
                if (bus.rw) begin
                    if (n[0]) begin
                        // Second consecutive odd read arms the write path.
                        if (pre_write) begin
                            write_en <= 1'b1;
                        end
                        pre_write <= 1'b1;
                    end else begin
                        write_en  <= 1'b0;
                        pre_write <= 1'b0;
                    end
                end else begin
                    pre_write <= 1'b0;
                    if (!n[0]) begin
                        write_en <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        off14 = {1'b0, !bank2_q, bus.address[11:0]};
        if (bus.address[15:13] == 3'b111) begin
            off14 = bus.address[13:0];
        end
    end

    assign bus.lcRead    = bus.busValid && bus.rw && hi_hit && read_ram;
    assign bus.lcWrite   = bus.busValid && !bus.rw && hi_hit && write_en;
    // Address is only meaningful for high-memory cycles; held at zero otherwise.
    assign bus.lcAddr    = (bus.busValid && hi_hit) ? {bank_sel, off14} : '0;
    assign bus.statusHit = stat_rd;
    assign bus.statusBit = stat_rd && ((bus.address[0]) ? bank2_q : read_ram);
    assign bus.bankSel   = bank_sel;
    assign bus.readRam   = read_ram;
    assign bus.writeEn   = write_en;
    assign bus.bank2     = bank2_q;
endmodule

// File: doc/lc_bank_ctrl.md
# lc_bank_ctrl

Parametrised language-card / Saturn-style bank controller for the $D000–$FFFF region. It decodes the slot's $C0n0–$C0nF soft switches and tracks read-RAM, write-enable, pre-write and $D000-bank state across NUM_BANKS 16 KB banks. It drives the RAM address and read/write qualifiers for high-memory accesses, and supplies the IIe $C011/$C012 status bits. It sits between the CPU bus and the main RAM path, beside the ROM and I/O decode.

## Interface
- NUM_BANKS, 1: number of 16 KB banks, one of 1, 2, 4 or 8. BW = max(1, clog2(NUM_BANKS)).
- SLOT, 0: switch base = $C080 + SLOT·$10; valid range 0–7.
- SATURN_MODE, 0: 0 = A2 aliased (legacy card); 1 = A2=1 switches select the 16 KB bank.
- clk6502  in  1  CPU clock; the only clock.
- cpuRst  in  1  reset, synchronous, active-high.
- busValid  in  1  one-cycle strobe per CPU bus cycle; address and rw are valid while high.
- address  in  16  CPU address.
- rw  in  1  1 = read, 0 = write.
- lcRead  out  1  current access is a read of $D000–$FFFF served from card RAM.
- lcWrite  out  1  current access is a write of $D000–$FFFF to card RAM.
- lcAddr  out  BW+14  card RAM address: {bankSel, off14}.
- statusHit  out  1  current access is a read of $C011 or $C012.
- statusBit  out  1  bit-7 value for the status read.
- bankSel  out  BW  selected 16 KB bank.
- readRam, writeEn, bank2  out  1 each  state visibility.

## Operation
- Switch hit: busValid=1 and address[15:4] == base[15:4]. Let n = address[3:0].
- Legacy switch (SATURN_MODE=0, or n[2]=0):
  - bank2 ← !n[3].
  - readRam ← (n[1:0]==00 or n[1:0]==11).
  - Read of odd n (n[0]=1):
    - If preWrite=1, writeEn ← 1.
    - preWrite ← 1.
  - Read of even n: writeEn ← 0 and preWrite ← 0.
  - Write of any n: preWrite ← 0. writeEn ← 0 if n[0]=0, otherwise unchanged.
- Saturn bank switch (SATURN_MODE=1 and n[2]=1):
  - bankSel ← {n[3], n[1:0]} truncated to BW bits (modulo NUM_BANKS).
  - readRam, writeEn, bank2 and preWrite are unchanged.
- Any bus cycle that is not a switch hit leaves preWrite and all other state unchanged. This includes idle cycles with busValid=0.
- High-memory hit: address[15:12] ≥ $D.
  - lcRead = busValid & rw & hit & readRam.
  - lcWrite = busValid & !rw & hit & writeEn.
  - When lcRead=0 on a high-memory read, the ROM serves the read.
- Address mapping for off14:
  - $E000–$FFFF: off14 = address[13:0], giving $2000–$3FFF.
  - $D000–$DFFF with bank2=1: off14 = {2'b00, address[11:0]}.
  - $D000–$DFFF with bank2=0: off14 = {2'b01, address[11:0]}.
- Status reads:
  - statusHit = busValid & rw & (address==$C011 | address==$C012).
  - statusBit = bank2 for $C011; readRam for $C012.
- Reset values: readRam=0, writeEn=0, preWrite=0, bank2=1, bankSel=0. All combinational outputs are 0 while busValid=0.

## Timing
- State registers update on the clk6502 rising edge where busValid=1.
- lcRead, lcWrite, lcAddr, statusHit and statusBit are combinational from the current address/rw/busValid and the pre-update state. A switch access therefore never affects its own cycle; the new mapping applies from the next busValid cycle.
- Latency is 0 cycles for decode and 1 cycle for a state change.
- Pre-write needs two consecutive switch accesses that are both odd-n reads. Non-switch cycles between them are allowed.
- cpuRst has priority over busValid in the same cycle: state goes to reset values, and the access is still decoded combinationally from the pre-reset state.
- Reset in the middle of a pre-write sequence clears preWrite. A following single odd read then gives writeEn=0.

## Test plan
- Reset, then read $D000 → lcRead=0; read $C012 → statusHit=1, statusBit=0; read $C011 → statusBit=1.
- Read $C083 → writeEn=0. Read $C083 again → writeEn=1. Write $D123 → lcWrite=1, lcAddr off14=$0123.
- Read $C081, write $C081, read $C081 → writeEn=0. A third read of $C081 → writeEn=1.
- Read $C08B twice, then read $D456 → lcRead=1, off14=$1456. Read $F000 → off14=$3000.
- SATURN_MODE=1, NUM_BANKS=8: read $C08E → bankSel=6, readRam unchanged. Read $C084 → bankSel=0.
- SATURN_MODE=0, SLOT=2: read $C0A5 → behaves as $C0A1 (readRam=0, preWrite=1), bankSel stays 0. Read $C085 → no state change.
